// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller: sequences single-word CPU data-port accesses onto the
// memory-mapped device slots. One strobe is held until the selected device
// responds or the access times out; malformed or unmapped requests are
// answered immediately with a bus error.
`timescale 1ns/1ps

module mmio_bus_controller #(
  parameter int          ADDR_W      = 30,
  parameter logic [3:0]  MMIO_REGION = 4'b1011,
  parameter logic [7:0]  SLOT_MASK   = 8'b0011_1000,
  parameter int          TIMEOUT     = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   Cpu_Address,
  input  logic                Cpu_ReadWord,
  input  logic                Cpu_WriteWord,
  input  logic [3:0]          Cpu_WriteBE,
  input  logic [31:0]         Cpu_WriteData,
  output logic [31:0]         Cpu_ReadData,
  output logic                Cpu_Ready,
  output logic                Cpu_BusError,
  output logic                Mmio_Hit,
  output logic [7:0]          Dev_Read,
  output logic [7:0]          Dev_Write,
  output logic [31:0]         Dev_WriteData,
  input  logic [255:0]        Dev_ReadData,
  input  logic [7:0]          Dev_Ready,
  output logic [7:0]          Err_Count,
  output logic [2:0]          Err_Slot
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Last counter value before the access is abandoned: the strobe is held
  // for exactly TIMEOUT cycles when no device answers.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [2:0]  slotReg;
  logic        opWrite;
  logic [15:0] timeoutCount;

  logic [2:0]  reqSlot;
  logic        request;
  logic        reqConflict;
  logic        reqSubWord;
  logic        reqUnmapped;
  logic [7:0]  reqOneHot;
  logic [31:0] devWord [8];
  logic        unusedAddrBits;

  // Address decode and request classification seen by the IDLE state.
  assign Mmio_Hit    = (Cpu_Address[ADDR_W-1 -: 4] == MMIO_REGION);
  assign reqSlot     = Cpu_Address[ADDR_W-5 -: 3];
  assign request     = Mmio_Hit && (Cpu_ReadWord || Cpu_WriteWord);
  assign reqConflict = Cpu_ReadWord && Cpu_WriteWord;
  assign reqSubWord  = Cpu_WriteWord && (Cpu_WriteBE != 4'b1111);
  assign reqUnmapped = !SLOT_MASK[reqSlot];
  assign reqOneHot   = 8'(1) << reqSlot;

  // Word offset bits below the slot field do not take part in decoding.
  assign unusedAddrBits = ^Cpu_Address[ADDR_W-8:0];

  // Split the flat device read bus into one word per slot.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_devWord
      assign devWord[gi] = Dev_ReadData[32*gi +: 32];
    end
  endgenerate

  // Access sequencer: decode in IDLE, hold one strobe in ACCESS, and give a
  // single-cycle response in RESP. All outputs except Mmio_Hit are registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      slotReg       <= 3'd0;
      opWrite       <= 1'b0;
      timeoutCount  <= 16'd0;
      Dev_Read      <= 8'd0;
      Dev_Write     <= 8'd0;
      Dev_WriteData <= 32'd0;
      Cpu_ReadData  <= 32'd0;
      Cpu_Ready     <= 1'b0;
      Cpu_BusError  <= 1'b0;
      Err_Count     <= 8'd0;
      Err_Slot      <= 3'd0;
    end else begin
      Cpu_Ready    <= 1'b0;
      Cpu_BusError <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            slotReg       <= reqSlot;
            opWrite       <= Cpu_WriteWord;
            Dev_WriteData <= Cpu_WriteData;
            if (reqConflict || reqSubWord || reqUnmapped) begin
              // Rejected without touching any device.
              state        <= RESP;
              Cpu_Ready    <= 1'b1;
              Cpu_BusError <= 1'b1;
              Cpu_ReadData <= 32'd0;
              Err_Slot     <= reqSlot;
              if (Err_Count != 8'hFF) Err_Count <= Err_Count + 8'd1;
            end else begin
              state        <= ACCESS;
              timeoutCount <= 16'd0;
              Dev_Read     <= Cpu_ReadWord  ? reqOneHot : 8'd0;
              Dev_Write    <= Cpu_WriteWord ? reqOneHot : 8'd0;
            end
          end
        end
        ACCESS: begin
          timeoutCount <= timeoutCount + 16'd1;
          // Ready wins over a timeout landing in the same cycle.
          if (Dev_Ready[slotReg]) begin
            state        <= RESP;
            Dev_Read     <= 8'd0;
            Dev_Write    <= 8'd0;
            Cpu_Ready    <= 1'b1;
            Cpu_ReadData <= opWrite ? 32'd0 : devWord[slotReg];
          end else if (timeoutCount == TIMEOUT_LAST) begin
            state        <= RESP;
            Dev_Read     <= 8'd0;
            Dev_Write    <= 8'd0;
            Cpu_Ready    <= 1'b1;
            Cpu_BusError <= 1'b1;
            Cpu_ReadData <= 32'd0;
            Err_Slot     <= slotReg;
            if (Err_Count != 8'hFF) Err_Count <= Err_Count + 8'd1;
          end
        end
        RESP: begin
          // Response is on the outputs this cycle; requests are ignored.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// tb_mmio_bus_controller: directed vectors with a scoreboard. Stimulus pushes
// the expected response of each access; a monitor pops and compares whenever
// the controller pulses Cpu_Ready. A device responder answers strobes after
// a programmable number of strobe cycles.
`timescale 1ns/1ps

module tb_mmio_bus_controller;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [29:0]  Cpu_Address;
  logic         Cpu_ReadWord;
  logic         Cpu_WriteWord;
  logic [3:0]   Cpu_WriteBE;
  logic [31:0]  Cpu_WriteData;
  logic [31:0]  Cpu_ReadData;
  logic         Cpu_Ready;
  logic         Cpu_BusError;
  logic         Mmio_Hit;
  logic [7:0]   Dev_Read;
  logic [7:0]   Dev_Write;
  logic [31:0]  Dev_WriteData;
  logic [255:0] Dev_ReadData;
  logic [7:0]   Dev_Ready = 8'd0;
  logic [7:0]   Err_Count;
  logic [2:0]   Err_Slot;

  typedef struct {
    string       name;
    logic [31:0] readData;
    logic        busError;
    logic [7:0]  errCount;
    logic [2:0]  errSlot;
  } exp_t;

  exp_t        expQ[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Responder state
  int          respDelay = 0;
  logic [7:0]  extraReady = 8'd0;
  int          strobeTotal = 0;
  int          runLen = 0;
  logic [7:0]  lastRead = 8'd0;
  logic [7:0]  lastWrite = 8'd0;
  logic [31:0] lastWdata = 32'd0;

  // Reference model of the error bookkeeping
  logic [7:0]  expErrCount = 8'd0;
  logic [2:0]  expErrSlot = 3'd0;

  mmio_bus_controller dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .Cpu_Address   (Cpu_Address),
    .Cpu_ReadWord  (Cpu_ReadWord),
    .Cpu_WriteWord (Cpu_WriteWord),
    .Cpu_WriteBE   (Cpu_WriteBE),
    .Cpu_WriteData (Cpu_WriteData),
    .Cpu_ReadData  (Cpu_ReadData),
    .Cpu_Ready     (Cpu_Ready),
    .Cpu_BusError  (Cpu_BusError),
    .Mmio_Hit      (Mmio_Hit),
    .Dev_Read      (Dev_Read),
    .Dev_Write     (Dev_Write),
    .Dev_WriteData (Dev_WriteData),
    .Dev_ReadData  (Dev_ReadData),
    .Dev_Ready     (Dev_Ready),
    .Err_Count     (Err_Count),
    .Err_Slot      (Err_Slot)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] mkAddr(input logic [2:0] slot);
    mkAddr = {4'b1011, slot, 23'h000010};
  endfunction

  // Monitor: every Cpu_Ready pulse must match the oldest expected response.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && Cpu_Ready === 1'b1) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: got Cpu_Ready=1 want no response");
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkVal({e.name, "_data"},     Cpu_ReadData,        e.readData);
        checkVal({e.name, "_buserr"},   32'(Cpu_BusError),   32'(e.busError));
        checkVal({e.name, "_errcount"}, 32'(Err_Count),      32'(e.errCount));
        checkVal({e.name, "_errslot"},  32'(Err_Slot),       32'(e.errSlot));
      end
    end
  end

  // Device responder: counts strobe cycles and raises Dev_Ready of the
  // strobed slot in the respDelay-th strobe cycle (never when respDelay=0).
  always @(negedge clock) begin
    if (reset_n === 1'b1 && (Dev_Read | Dev_Write) != 8'd0) begin
      strobeTotal++;
      runLen++;
      lastRead  = Dev_Read;
      lastWrite = Dev_Write;
      lastWdata = Dev_WriteData;
      if (respDelay != 0 && runLen == respDelay)
        Dev_Ready = (Dev_Read | Dev_Write) | extraReady;
      else
        Dev_Ready = extraReady;
    end else begin
      runLen    = 0;
      Dev_Ready = extraReady;
    end
  end

  task automatic doAccess(input string name, input logic [2:0] slot, input logic rd,
                          input logic wr, input logic [3:0] be, input logic [31:0] wdata,
                          input int delay, input logic expErr, input int expStrobes,
                          input logic [31:0] expData);
    exp_t e;
    int   start;
    int   waitCycles;
    logic [7:0] oneHot;
    oneHot = 8'(1) << slot;
    respDelay = delay;
    if (expErr) begin
      if (expErrCount != 8'hFF) expErrCount = expErrCount + 8'd1;
      expErrSlot = slot;
    end
    e.name     = name;
    e.readData = expErr ? 32'd0 : expData;
    e.busError = expErr;
    e.errCount = expErrCount;
    e.errSlot  = expErrSlot;
    expQ.push_back(e);
    @(negedge clock);
    start         = strobeTotal;
    Cpu_Address   = mkAddr(slot);
    Cpu_ReadWord  = rd;
    Cpu_WriteWord = wr;
    Cpu_WriteBE   = be;
    Cpu_WriteData = wdata;
    waitCycles = 0;
    do begin
      @(negedge clock);
      waitCycles++;
    end while (Cpu_Ready !== 1'b1 && waitCycles < 400);
    if (Cpu_Ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no Cpu_Ready after %0d cycles want a response", name, waitCycles);
    end
    Cpu_ReadWord  = 1'b0;
    Cpu_WriteWord = 1'b0;
    checkVal({name, "_strobe_cycles"}, 32'(strobeTotal - start), 32'(expStrobes));
    checkVal({name, "_dev_wdata"}, Dev_WriteData, wdata);
    if (expStrobes > 0) begin
      checkVal({name, "_dev_read"},  32'(lastRead),  32'(rd ? oneHot : 8'd0));
      checkVal({name, "_dev_write"}, 32'(lastWrite), 32'(wr ? oneHot : 8'd0));
      if (wr) checkVal({name, "_strobe_wdata"}, lastWdata, wdata);
    end
    @(negedge clock);
    checkVal({name, "_ready_pulse"}, 32'(Cpu_Ready), 32'd0);
    respDelay = 0;
  endtask

  initial begin
    reset_n       = 1'b0;
    Cpu_Address   = 30'd0;
    Cpu_ReadWord  = 1'b0;
    Cpu_WriteWord = 1'b0;
    Cpu_WriteBE   = 4'b0000;
    Cpu_WriteData = 32'd0;
    for (int i = 0; i < 8; i++) Dev_ReadData[32*i +: 32] = 32'hAB00_0000 | 32'(i);
    Dev_ReadData[191:160] = 32'h0000_00A5;

    #12;
    checkVal("rst_ready",   32'(Cpu_Ready),    32'd0);
    checkVal("rst_buserr",  32'(Cpu_BusError), 32'd0);
    checkVal("rst_rdata",   Cpu_ReadData,      32'd0);
    checkVal("rst_devread", 32'(Dev_Read),     32'd0);
    checkVal("rst_devwr",   32'(Dev_Write),    32'd0);
    checkVal("rst_devwd",   Dev_WriteData,     32'd0);
    checkVal("rst_errcnt",  32'(Err_Count),    32'd0);
    checkVal("rst_errslot", 32'(Err_Slot),     32'd0);
    Cpu_Address = mkAddr(3'd5);
    #1;
    checkVal("mmio_hit", 32'(Mmio_Hit), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;

    // Successful accesses
    doAccess("rd_slot5", 3'd5, 1'b1, 1'b0, 4'b0000, 32'h0, 3, 1'b0, 3, 32'h0000_00A5);
    doAccess("wr_slot4", 3'd4, 1'b0, 1'b1, 4'b1111, 32'h0000_1234, 2, 1'b0, 2, 32'h0);
    // Error paths
    doAccess("wr_byte",   3'd4, 1'b0, 1'b1, 4'b0001, 32'h0000_0055, 1, 1'b1, 0, 32'h0);
    doAccess("rd_unmap0", 3'd0, 1'b1, 1'b0, 4'b0000, 32'h0, 1, 1'b1, 0, 32'h0);
    doAccess("rd_tmo3",   3'd3, 1'b1, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 255, 32'h0);
    doAccess("rd_wr_conf", 3'd5, 1'b1, 1'b1, 4'b1111, 32'hCAFE_0001, 1, 1'b1, 0, 32'h0);
    // Unselected ready ignored; ready and timeout together means success
    extraReady = 8'h10;
    doAccess("rd_race3",  3'd3, 1'b1, 1'b0, 4'b0000, 32'h0, 255, 1'b0, 255, 32'hAB00_0003);
    extraReady = 8'h00;

    // Non-MMIO request is ignored
    @(negedge clock);
    Cpu_Address  = {4'b0000, 3'd5, 23'h000010};
    Cpu_ReadWord = 1'b1;
    #1;
    checkVal("nonmmio_hit", 32'(Mmio_Hit), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkVal("nonmmio_strobe", 32'(Dev_Read | Dev_Write), 32'd0);
    end
    Cpu_ReadWord = 1'b0;

    // Reset in the middle of an access aborts it without a response
    @(negedge clock);
    respDelay    = 0;
    Cpu_Address  = mkAddr(3'd3);
    Cpu_ReadWord = 1'b1;
    repeat (4) @(negedge clock);
    checkVal("abort_pre_strobe", 32'(Dev_Read), 32'h08);
    #2;
    reset_n      = 1'b0;
    Cpu_ReadWord = 1'b0;
    #1;
    checkVal("abort_devread", 32'(Dev_Read),  32'd0);
    checkVal("abort_errcnt",  32'(Err_Count), 32'd0);
    checkVal("abort_errslot", 32'(Err_Slot),  32'd0);
    expErrCount = 8'd0;
    expErrSlot  = 3'd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkVal("abort_idle_strobe", 32'(Dev_Read | Dev_Write), 32'd0);
      checkVal("abort_idle_ready",  32'(Cpu_Ready), 32'd0);
    end
    doAccess("rd_after_rst", 3'd5, 1'b1, 1'b0, 4'b0000, 32'h0, 1, 1'b0, 1, 32'h0000_00A5);

    // Error counter saturation
    for (int i = 0; i < 260; i++)
      doAccess("sat_err", 3'd7, 1'b1, 1'b0, 4'b0000, 32'h0, 1, 1'b1, 0, 32'h0);
    checkVal("sat_errcnt", 32'(Err_Count), 32'hFF);

    repeat (3) @(negedge clock);
    checkVal("queue_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_bus_controller.md
Name: mmio_bus_controller

Overview:
- Sequences CPU data-port word accesses onto the memory-mapped I/O devices (UART, LED, switches, future slots).
- Sits between the MIPS32 data-memory interface and the MMIO devices, replacing the combinational MMIO decode.
- Decodes the device slot, holds a Read/Write strobe to exactly one device until it responds, and returns data and Ready to the core.
- Detects unmapped slots, sub-word writes, conflicting requests and device timeouts, and reports them as bus errors.

Parameters:
- ADDR_W, 30, width of the word address (PABITS-2).
- MMIO_REGION, 4'b1011, value of Cpu_Address[29:26] that selects MMIO space.
- SLOT_MASK, 8'b0011_1000, bit i set means device slot i is populated (UART=3, LED=4, Switches=5).
- TIMEOUT, 255, maximum cycles in ACCESS before a timeout error; legal range 1..65535.

Ports:
- clock  in  1  system clock; all state is rising-edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- Cpu_Address  in  ADDR_W  core data word address.
- Cpu_ReadWord  in  1  level; single-word read request.
- Cpu_WriteWord  in  1  level; single-word write request.
- Cpu_WriteBE  in  4  write byte enables.
- Cpu_WriteData  in  32  write data.
- Cpu_ReadData  out  32  read data, valid while Cpu_Ready=1.
- Cpu_Ready  out  1  one-cycle completion pulse.
- Cpu_BusError  out  1  qualifies Cpu_Ready; 1 means the access failed.
- Mmio_Hit  out  1  combinational; high when Cpu_Address[29:26]==MMIO_REGION. The top level uses it to gate main memory.
- Dev_Read  out  8  one-hot read strobe per slot.
- Dev_Write  out  8  one-hot write strobe per slot.
- Dev_WriteData  out  32  registered write data to devices.
- Dev_ReadData  in  256  slot i data on bits [32i+31:32i].
- Dev_Ready  in  8  per-slot completion.
- Err_Count  out  8  saturating bus-error count.
- Err_Slot  out  3  slot of the most recent error.

Behaviour:
- Reset (async, reset_n=0) forces the following, combinationally on assertion:
  - state=IDLE;
  - Dev_Read, Dev_Write = 0;
  - Cpu_Ready, Cpu_BusError = 0;
  - Cpu_ReadData, Dev_WriteData = 0;
  - Err_Count, Err_Slot = 0;
  - timeout counter = 0.
- Reset mid-access aborts the access. No response is ever produced for it.
- Slot = Cpu_Address[25:23]. A request is a cycle with Mmio_Hit=1 and (Cpu_ReadWord or Cpu_WriteWord).
- States: IDLE, ACCESS, RESP.
- IDLE, on a request, latches slot, op, Cpu_WriteData → Dev_WriteData, then moves by the first matching rule:
  - both ReadWord and WriteWord set → RESP, error;
  - write with Cpu_WriteBE != 4'b1111 → RESP, error;
  - SLOT_MASK[slot]=0 → RESP, error;
  - otherwise → ACCESS, counter cleared.
- IDLE ignores non-MMIO requests.
- ACCESS:
  - Dev_Read[slot] or Dev_Write[slot] is held high; all other strobe bits are 0.
  - The counter increments each cycle.
  - Dev_Ready[slot]=1 → latch Dev_ReadData slot word into Cpu_ReadData (writes latch 0) → RESP, no error. Strobes drop in the same edge.
  - Counter==TIMEOUT-1 with no ready → RESP, error, strobe dropped.
  - Ready takes precedence over timeout in the same cycle.
  - Dev_Ready bits of unselected slots are ignored.
- RESP:
  - Cpu_Ready=1 for exactly one cycle; Cpu_BusError=1 if error; → IDLE.
  - On error, Cpu_ReadData=0, Err_Slot=latched slot, Err_Count+1 saturating at 255.
  - Requests during RESP are ignored.
  - The core deasserts its request in the cycle after Cpu_Ready, so IDLE never re-issues.
- Latency: request sampled at edge N; strobe high in cycle N+1; device ready in cycle N+k (k≥1); Cpu_Ready high in cycle N+k+1. Error-path latency is 1 cycle (Cpu_Ready in cycle N+1).
- Outputs Cpu_ReadData, Cpu_Ready, Cpu_BusError, Dev_* are registered. Only Mmio_Hit is combinational.

Test Plan:
- Read slot 5, Dev_ReadData[191:160]=32'h0000_00A5, Dev_Ready[5] rising 3 cycles after the strobe → Dev_Read=8'b0010_0000 held for 3 cycles, then Cpu_ReadData=32'hA5, Cpu_Ready one pulse, Cpu_BusError=0.
- Write slot 4, BE=4'b1111, data 32'h1234 → Dev_Write=8'b0001_0000 and Dev_WriteData=32'h1234 until Dev_Ready[4], then one Cpu_Ready. Byte write with BE=4'b0001 → no strobe, Cpu_Ready+Cpu_BusError in the next cycle, Err_Count=1, Err_Slot=4.
- Read slot 0 (unmapped) → no strobe, error response, Err_Slot=0. Read slot 3 with Dev_Ready never asserted and TIMEOUT=255 → strobe high exactly 255 cycles, then error response, Cpu_ReadData=0.
- Read slot 3 with Dev_Ready[4] asserted and Dev_Ready[3] low → still waiting. Then Dev_Ready[3] and timeout in the same cycle → success, no error.
- Assert reset_n=0 mid-ACCESS → Dev_Read=0 immediately without a clock edge. After release: state IDLE, Err_Count=0, no Cpu_Ready.
- Force 260 errors → Err_Count saturates at 8'hFF. Non-MMIO request (Cpu_Address[29:26]=4'b0000) → Mmio_Hit=0 and no strobes.
